// File: rtl/acc_drain_ctrl_if.sv
// Handshake bundle between the accumulator-bank sequencer and its surroundings.
// slave = the sequencer itself, master = whoever drives jobs and observes enables.
interface acc_drain_ctrl_if #(
    parameter int PE_SIZE = 16,
    parameter int TILE_W  = 8
);
    logic                start_i;
    logic [TILE_W-1:0]   num_tiles_i;
    logic                psum_valid_i;
    logic [PE_SIZE-1:0]  wren_o;
    logic [PE_SIZE-1:0]  rden_o;
    logic [PE_SIZE-1:0]  sel_o;
    logic [PE_SIZE-1:0]  out_valid_o;
    logic                busy_o;
    logic                done_o;
    logic                err_o;

    modport slave (
        input  start_i, num_tiles_i, psum_valid_i,
        output wren_o, rden_o, sel_o, out_valid_o, busy_o, done_o, err_o
    );

    modport master (
        output start_i, num_tiles_i, psum_valid_i,
        input  wren_o, rden_o, sel_o, out_valid_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/acc_drain_ctrl.sv
// Sequencer for the per-column accumulator FIFO bank: skewed write/read/feedback
// enables while K-tiles accumulate, then a drain pass with per-column output strobes.
module acc_drain_ctrl #(
    parameter int PE_SIZE    = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int TILE_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    acc_drain_ctrl_if.slave   bus
);
    localparam int ROW_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int DCNT_W = $clog2(PE_SIZE + FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

    state_t              r_state, w_next;
    logic [TILE_W-1:0]   r_ntiles, r_tile;
    logic [ROW_W-1:0]    r_row;
    logic [DCNT_W-1:0]   r_dcnt;
    logic                r_err;
    logic [PE_SIZE-2:0]  r_wsh, r_rsh, r_ssh, r_vsh;

    logic w_w0, w_r0, w_s0, w_v0, w_done, w_accept, w_perr;
    logic w_row_last, w_tile_last;
    logic [PE_SIZE-1:0] w_wren, w_rden, w_sel, w_oval;

    assign w_row_last  = (r_row == ROW_W'(FIFO_DEPTH - 1));
    assign w_tile_last = (r_tile == r_ntiles - TILE_W'(1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_w0     = 1'b0;
        w_r0     = 1'b0;
        w_s0     = 1'b0;
        w_v0     = 1'b0;
        w_done   = 1'b0;
        w_accept = 1'b0;
        w_perr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_perr = bus.psum_valid_i;
                if (bus.start_i) begin
                    w_accept = 1'b1;
                    w_next   = S_ACCUM;
                end
            end
            S_ACCUM: begin
                // First tile seeds the FIFOs with zero feedback; later tiles read-modify-write.
                w_w0 = bus.psum_valid_i;
                if (r_tile != '0) begin
                    w_r0 = bus.psum_valid_i;
                    w_s0 = bus.psum_valid_i;
                end
                if (bus.psum_valid_i && w_row_last && w_tile_last) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_perr = bus.psum_valid_i;
                if (r_dcnt < DCNT_W'(FIFO_DEPTH)) begin
                    w_r0 = 1'b1;
                    w_s0 = 1'b1;
                    w_v0 = 1'b1;
                end
                // Wait for the last column's final strobe to leave the skew pipe.
                if (r_dcnt == DCNT_W'(PE_SIZE + FIFO_DEPTH - 1)) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ntiles <= '0;
            r_tile   <= '0;
            r_row    <= '0;
            r_dcnt   <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ntiles <= (bus.num_tiles_i == '0) ? TILE_W'(1) : bus.num_tiles_i;
                r_tile   <= '0;
                r_row    <= '0;
                r_err    <= 1'b0;
            end else begin
                if (w_perr) r_err <= 1'b1;
                if (r_state == S_ACCUM && bus.psum_valid_i) begin
                    if (w_row_last) begin
                        r_row  <= '0;
                        r_tile <= r_tile + TILE_W'(1);
                    end else begin
                        r_row  <= r_row + ROW_W'(1);
                    end
                end
            end
            r_dcnt <= (r_state == S_DRAIN) ? r_dcnt + DCNT_W'(1) : '0;
        end
    end

    // Column j sees the column-0 decision j cycles later, matching the array's data skew.
    assign w_wren = {r_wsh, w_w0};
    assign w_rden = {r_rsh, w_r0};
    assign w_sel  = {r_ssh, w_s0};
    assign w_oval = {r_vsh, w_v0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wsh <= '0;
            r_rsh <= '0;
            r_ssh <= '0;
            r_vsh <= '0;
        end else begin
            r_wsh <= w_wren[PE_SIZE-2:0];
            r_rsh <= w_rden[PE_SIZE-2:0];
            r_ssh <= w_sel[PE_SIZE-2:0];
            r_vsh <= w_oval[PE_SIZE-2:0];
        end
    end

    assign bus.wren_o      = w_wren;
    assign bus.rden_o      = w_rden;
    assign bus.sel_o       = w_sel;
    assign bus.out_valid_o = w_oval;
    assign bus.busy_o      = (r_state != S_IDLE) && !w_done;
    assign bus.done_o      = w_done;
    assign bus.err_o       = r_err;
endmodule

// File: tb/tb_acc_drain_ctrl.sv
// Bench for acc_drain_ctrl: schedule-based reference for enables plus a FIFO/adder
// model of the accumulator bank that checks the drained sums.
module tb_acc_drain_ctrl;
    localparam int PE = 4, DEPTH = 4, TW = 8;
    localparam int MAXC = 4096, MAXR = 1100;
    localparam int VW = 4 * PE + 3;
    localparam int B_BUSY = 2, B_DONE = 1, B_ERR = 0;
    localparam int B_OV = 3, B_SEL = 3 + PE, B_RD = 3 + 2 * PE, B_WR = 3 + 3 * PE;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    acc_drain_ctrl_if #(.PE_SIZE(PE), .TILE_W(TW)) bus ();
    acc_drain_ctrl #(.PE_SIZE(PE), .FIFO_DEPTH(DEPTH), .TILE_W(TW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int checks = 0, errors = 0;
    bit model_err = 1'b0;
    logic [VW-1:0] exp_vec [MAXC];
    logic [VW-1:0] obs_vec [MAXC];
    int ncyc;
    int pdata [MAXR][PE];
    int rowat [MAXC];
    bit pvin [MAXC];
    bit c0w [MAXC], c0r [MAXC], c0s [MAXC], c0v [MAXC];
    int fq [PE][$];
    int q_out [PE][$];
    int exp_out [PE][DEPTH];
    bit fifo_bad;

    // One job: build the expected schedule from the rules, drive it, record outputs
    // and feed the observed enables through a model of the FIFO bank.
    task automatic run_job(input int nt_drv, input int gapmax, input int fixed,
                           input int err_off, input int busy_at, input int abort_at);
        int nt, nrows, t, last, d0, dn, src, head, ps;
        logic [PE-1:0] w, r, s, v;
        logic busy, done, err;
        nt = (nt_drv == 0) ? 1 : nt_drv;
        nrows = nt * DEPTH;
        for (int i = 0; i < MAXC; i++) begin
            rowat[i] = -1; pvin[i] = 0; c0w[i] = 0; c0r[i] = 0; c0s[i] = 0; c0v[i] = 0;
        end
        t = 2;
        for (int k = 0; k < nrows; k++) begin
            if (gapmax > 0) t += $urandom_range(0, gapmax);
            rowat[t] = k; pvin[t] = 1; c0w[t] = 1;
            if (k >= DEPTH) begin c0r[t] = 1; c0s[t] = 1; end
            for (int j = 0; j < PE; j++)
                pdata[k][j] = fixed ? (k / DEPTH) + 1 : int'($urandom_range(0, 1000));
            last = t;
            t++;
        end
        d0 = last + 1;
        for (int d = 0; d < DEPTH; d++) begin c0r[d0+d] = 1; c0s[d0+d] = 1; c0v[d0+d] = 1; end
        dn = d0 + PE + DEPTH - 1;
        ncyc = dn + 3;
        if (err_off >= 0) pvin[d0 + err_off] = 1;
        if (abort_at >= 0) begin
            ncyc = abort_at + PE + DEPTH + 6;
            for (int i = abort_at + 1; i < MAXC; i++) begin pvin[i] = 0; rowat[i] = -1; end
        end
        for (int tt = 0; tt < ncyc; tt++) begin
            for (int j = 0; j < PE; j++) begin
                src = tt - j;
                if (src >= 0 && !(abort_at >= 0 && tt > abort_at)) begin
                    w[j] = c0w[src]; r[j] = c0r[src]; s[j] = c0s[src]; v[j] = c0v[src];
                end else begin
                    w[j] = 0; r[j] = 0; s[j] = 0; v[j] = 0;
                end
            end
            busy = (tt >= 1) && (tt < dn) && !(abort_at >= 0 && tt > abort_at);
            done = (tt == dn) && (abort_at < 0);
            if (tt == 0) err = model_err;
            else err = (err_off >= 0) && (tt > d0 + err_off) && (abort_at < 0);
            exp_vec[tt] = {w, r, s, v, busy, done, err};
        end
        model_err = (err_off >= 0) && (abort_at < 0);
        for (int j = 0; j < PE; j++) begin
            fq[j].delete(); q_out[j].delete();
            for (int rr = 0; rr < DEPTH; rr++) begin
                exp_out[j][rr] = 0;
                for (int tl = 0; tl < nt; tl++) exp_out[j][rr] += pdata[tl*DEPTH+rr][j];
            end
        end
        fifo_bad = 0;
        for (int tt = 0; tt < ncyc; tt++) begin
            @(posedge clk); #1;
            rst = (abort_at >= 0 && tt == abort_at);
            bus.start_i = (tt == 0) || (tt == busy_at);
            bus.num_tiles_i = (tt == 0) ? TW'(nt_drv) : TW'($urandom_range(0, 255));
            bus.psum_valid_i = pvin[tt];
            @(negedge clk);
            obs_vec[tt] = {bus.wren_o, bus.rden_o, bus.sel_o, bus.out_valid_o,
                           bus.busy_o, bus.done_o, bus.err_o};
            for (int j = 0; j < PE; j++) begin
                head = (fq[j].size() > 0) ? fq[j][0] : 0;
                if ((bus.sel_o[j] || bus.rden_o[j] || bus.out_valid_o[j]) && fq[j].size() == 0)
                    fifo_bad = 1;
                src = tt - j;
                ps = (src >= 0 && rowat[src] >= 0) ? pdata[rowat[src]][j] : 0;
                if (bus.out_valid_o[j]) q_out[j].push_back(head);
                if (bus.rden_o[j] && fq[j].size() > 0) void'(fq[j].pop_front());
                if (bus.wren_o[j]) fq[j].push_back((bus.sel_o[j] ? head : 0) + ps);
            end
        end
        @(posedge clk); #1;
        rst = 0; bus.start_i = 0; bus.psum_valid_i = 0;
    endtask

    task automatic test_reset();
        rst = 1; bus.start_i = 0; bus.num_tiles_i = '0; bus.psum_valid_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.wren_o, bus.rden_o, bus.sel_o, bus.out_valid_o, bus.busy_o, bus.done_o, bus.err_o} !== '0) begin
            errors++;
            $display("FAIL reset outputs got %h want 0",
                     {bus.wren_o, bus.rden_o, bus.sel_o, bus.out_valid_o, bus.busy_o, bus.done_o, bus.err_o});
        end
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_basic();
        run_job(1, 0, 0, -1, -1, -1);
        for (int t = 0; t < ncyc; t++) begin
            checks++;
            if (obs_vec[t] !== exp_vec[t]) begin
                errors++; $display("FAIL basic cyc %0d got %h want %h", t, obs_vec[t], exp_vec[t]);
            end
        end
        checks += 6;
        if (obs_vec[2][B_WR] !== 1'b1)     begin errors++; $display("FAIL basic wren0@2 got %b want 1", obs_vec[2][B_WR]); end
        if (obs_vec[8][B_WR+3] !== 1'b1)   begin errors++; $display("FAIL basic wren3@8 got %b want 1", obs_vec[8][B_WR+3]); end
        if (obs_vec[6][B_RD] !== 1'b1)     begin errors++; $display("FAIL basic rden0@6 got %b want 1", obs_vec[6][B_RD]); end
        if (obs_vec[12][B_OV+3] !== 1'b1)  begin errors++; $display("FAIL basic oval3@12 got %b want 1", obs_vec[12][B_OV+3]); end
        if (obs_vec[13][B_DONE] !== 1'b1)  begin errors++; $display("FAIL basic done@13 got %b want 1", obs_vec[13][B_DONE]); end
        if (obs_vec[12][B_DONE] !== 1'b0)  begin errors++; $display("FAIL basic done@12 got %b want 0", obs_vec[12][B_DONE]); end
        for (int j = 0; j < PE; j++)
            for (int r = 0; r < DEPTH; r++) begin
                checks++;
                if (q_out[j].size() <= r || q_out[j][r] != exp_out[j][r]) begin
                    errors++; $display("FAIL basic sum col %0d row %0d got %0d want %0d", j, r,
                                       (q_out[j].size() > r) ? q_out[j][r] : -1, exp_out[j][r]);
                end
            end
    endtask

    task automatic test_multi_tile();
        run_job(3, 0, 1, -1, -1, -1);
        for (int t = 0; t < ncyc; t++) begin
            checks++;
            if (obs_vec[t] !== exp_vec[t]) begin
                errors++; $display("FAIL multi cyc %0d got %h want %h", t, obs_vec[t], exp_vec[t]);
            end
        end
        for (int j = 0; j < PE; j++)
            for (int r = 0; r < DEPTH; r++) begin
                checks++;
                if (q_out[j].size() <= r || q_out[j][r] != 6) begin
                    errors++; $display("FAIL multi sum col %0d row %0d got %0d want 6", j, r,
                                       (q_out[j].size() > r) ? q_out[j][r] : -1);
                end
            end
        checks++;
        if (fifo_bad) begin errors++; $display("FAIL multi fifo underflow got 1 want 0"); end
    endtask

    task automatic test_stall();
        for (int n = 0; n < 3; n++) begin
            run_job(2 + n, 2, 0, -1, -1, -1);
            for (int t = 0; t < ncyc; t++) begin
                checks++;
                if (obs_vec[t] !== exp_vec[t]) begin
                    errors++; $display("FAIL stall cyc %0d got %h want %h", t, obs_vec[t], exp_vec[t]);
                end
            end
            for (int j = 0; j < PE; j++)
                for (int r = 0; r < DEPTH; r++) begin
                    checks++;
                    if (q_out[j].size() <= r || q_out[j][r] != exp_out[j][r]) begin
                        errors++; $display("FAIL stall sum col %0d row %0d want %0d", j, r, exp_out[j][r]);
                    end
                end
            checks++;
            if (fifo_bad || fq[0].size() != 0) begin
                errors++; $display("FAIL stall fifo state got bad=%0d size=%0d want 0 0", fifo_bad, fq[0].size());
            end
        end
    endtask

    task automatic test_drain_err();
        run_job(2, 1, 0, 2, -1, -1);
        for (int t = 0; t < ncyc; t++) begin
            checks++;
            if (obs_vec[t] !== exp_vec[t]) begin
                errors++; $display("FAIL drain_err cyc %0d got %h want %h", t, obs_vec[t], exp_vec[t]);
            end
        end
        for (int j = 0; j < PE; j++)
            for (int r = 0; r < DEPTH; r++) begin
                checks++;
                if (q_out[j].size() <= r || q_out[j][r] != exp_out[j][r]) begin
                    errors++; $display("FAIL drain_err sum col %0d row %0d want %0d", j, r, exp_out[j][r]);
                end
            end
    endtask

    task automatic test_busy_start();
        run_job(0, 1, 0, -1, 5, -1);
        for (int t = 0; t < ncyc; t++) begin
            checks++;
            if (obs_vec[t] !== exp_vec[t]) begin
                errors++; $display("FAIL busy_start cyc %0d got %h want %h", t, obs_vec[t], exp_vec[t]);
            end
        end
        checks++;
        if (obs_vec[1][B_ERR] !== 1'b0) begin
            errors++; $display("FAIL busy_start err_clear got %b want 0", obs_vec[1][B_ERR]);
        end
    endtask

    task automatic test_idle_err();
        @(posedge clk); #1;
        bus.psum_valid_i = 1;
        @(negedge clk);
        checks++;
        if ({bus.wren_o, bus.rden_o, bus.out_valid_o} !== '0) begin
            errors++; $display("FAIL idle_err enables got %h want 0", {bus.wren_o, bus.rden_o, bus.out_valid_o});
        end
        @(posedge clk); #1;
        bus.psum_valid_i = 0;
        @(negedge clk);
        checks++;
        if (bus.err_o !== 1'b1) begin errors++; $display("FAIL idle_err err got %b want 1", bus.err_o); end
        model_err = 1;
    endtask

    task automatic test_reset_mid();
        run_job(2, 1, 0, -1, -1, 6);
        for (int t = 0; t < ncyc; t++) begin
            checks++;
            if (obs_vec[t] !== exp_vec[t]) begin
                errors++; $display("FAIL reset_mid cyc %0d got %h want %h", t, obs_vec[t], exp_vec[t]);
            end
        end
        run_job(1, 0, 0, -1, -1, -1);
        for (int t = 0; t < ncyc; t++) begin
            checks++;
            if (obs_vec[t] !== exp_vec[t]) begin
                errors++; $display("FAIL after_reset cyc %0d got %h want %h", t, obs_vec[t], exp_vec[t]);
            end
        end
    endtask

    task automatic test_max_tiles();
        run_job(255, 0, 0, -1, -1, -1);
        for (int t = 0; t < ncyc; t++) begin
            checks++;
            if (obs_vec[t] !== exp_vec[t]) begin
                errors++; $display("FAIL max_tiles cyc %0d got %h want %h", t, obs_vec[t], exp_vec[t]);
            end
        end
        for (int j = 0; j < PE; j++)
            for (int r = 0; r < DEPTH; r++) begin
                checks++;
                if (q_out[j].size() <= r || q_out[j][r] != exp_out[j][r]) begin
                    errors++; $display("FAIL max_tiles sum col %0d row %0d want %0d", j, r, exp_out[j][r]);
                end
            end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            run_job($urandom_range(1, 5), $urandom_range(0, 3), 0, -1, -1, -1);
            for (int t = 0; t < ncyc; t++) begin
                checks++;
                if (obs_vec[t] !== exp_vec[t]) begin
                    errors++; $display("FAIL random cyc %0d got %h want %h", t, obs_vec[t], exp_vec[t]);
                end
            end
            for (int j = 0; j < PE; j++)
                for (int r = 0; r < DEPTH; r++) begin
                    checks++;
                    if (q_out[j].size() <= r || q_out[j][r] != exp_out[j][r]) begin
                        errors++; $display("FAIL random sum col %0d row %0d want %0d", j, r, exp_out[j][r]);
                    end
                end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_tile();
        test_stall();
        test_drain_err();
        test_busy_start();
        test_idle_err();
        test_reset_mid();
        test_max_tiles();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
